multicycle_control: RTL
=======================

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 The block SHALL expose parameter ALUOP_W, default 4, giving the ALUOp output width (minimum 4; upper bits zero).
REQ-002 The block SHALL expose parameter MEM_TIMEOUT, default 15, giving the maximum MEM-state wait cycles before trap (range 1..255).
REQ-003 The block SHALL expose parameter EN_ORI, default 1; when 1 ori SHALL be legal, and when 0 ori SHALL decode illegal.
REQ-004 The block SHALL expose parameter CNT_W, default 16, giving the retired-counter width.
REQ-005 The block SHALL have a single clock, clk, and a synchronous, active-high reset, rst.
REQ-006 clk  input  1  — rising-edge clock.
REQ-007 rst  input  1  — synchronous active-high reset.
REQ-008 instr_valid  input  1  — fetch side presents instruction.
REQ-009 instruction  input  32  — RV32 instruction word.
REQ-010 instr_ready  output  1  — block accepts instruction this cycle.
REQ-011 mem_ready  input  1  — data memory completes access.
REQ-012 ALUOp  output  ALUOP_W  — ALU operation code.
REQ-013 ALUSrc, MemtoReg, MemRead, MemWrite, RegWrite, Branch  output  1 each  — datapath controls.
REQ-014 PCWrite  output  1  — one-cycle PC update strobe.
REQ-015 IRWrite  output  1  — instruction-register load strobe.
REQ-016 illegal  output  1  — sticky trap flag.
REQ-017 state  output  3  — current FSM state encoding.
REQ-018 retired  output  CNT_W  — count of completed instructions.

Function
REQ-019 The FSM SHALL implement states IDLE=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5; codes 6–7 SHALL go to TRAP.
REQ-020 In IDLE, instr_ready SHALL be 1; on instr_valid the block SHALL latch instruction into an internal IR, pulse IRWrite, and go to DECODE.
REQ-021 In DECODE, the block SHALL classify IR: add/sub/and/or (opcode 0110011, funct7 0000000 or 0100000 for sub only), beq (1100011/000), blt (1100011/100), lw (0000011/010), sw (0100011/010), lui (0110111), addi (0010011/000), and ori (0010011/110, per EN_ORI); all others SHALL go to TRAP, else to EXEC.
REQ-022 ALUOp SHALL be: and=0000, or/ori=0001, add/addi/lw/sw=0010, sub/beq/blt=0110, lui=0100; ALUSrc SHALL be 1 for lw/sw/lui/addi/ori; these SHALL be held from EXEC through instruction end.
REQ-023 In EXEC, R/I/lui SHALL go to WB, lw/sw to MEM, and beq/blt SHALL assert Branch and PCWrite for that cycle, increment retired, and return to IDLE.
REQ-024 In MEM, MemRead (lw) or MemWrite (sw) SHALL be held until mem_ready; on mem_ready lw SHALL go to WB, while sw SHALL pulse PCWrite, increment retired, and go to IDLE.
REQ-025 An 8-bit wait counter SHALL clear on MEM entry and increment each MEM cycle without mem_ready; reaching MEM_TIMEOUT SHALL drop MemRead/MemWrite and go to TRAP.
REQ-026 mem_ready in the same cycle the counter reaches MEM_TIMEOUT SHALL take priority (access completes).
REQ-027 In WB, RegWrite and PCWrite SHALL be 1, MemtoReg SHALL be 1 only for lw, and retired SHALL increment; next state SHALL be IDLE.
REQ-028 In TRAP, illegal SHALL be 1, all strobes and instr_ready SHALL be 0, and the block SHALL remain there until rst.
REQ-029 retired SHALL wrap modulo 2^CNT_W and never saturate.
REQ-030 instr_valid outside IDLE SHALL be ignored; the IR SHALL be unchanged.
REQ-031 Latency SHALL be: R/I/lui 4 cycles from acceptance to next instr_ready; branch 3; lw 5+waits; sw 4+waits.

Reset
REQ-032 rst high at a clock edge SHALL force state=IDLE, IR=0, wait counter=0, retired=0, illegal=0, and all control outputs 0 except instr_ready=1, from any state including MEM mid-access and TRAP.
REQ-033 rst SHALL take priority over every simultaneous input event.

Verification
REQ-034 The bench SHALL check: 0x002081B3 (add) accepted -> states 1,2,4,0; in WB, RegWrite=1, ALUOp=0010, ALUSrc=0; retired=1.
REQ-035 The bench SHALL check: 0x0000A283 (lw) with mem_ready after 3 cycles -> MemRead=1 for 4 MEM cycles, WB MemtoReg=1, RegWrite=1.
REQ-036 The bench SHALL check: 0x0020A223 (sw) with mem_ready held low -> after MEM_TIMEOUT=15 cycles, state=5, illegal=1, MemWrite=0.
REQ-037 The bench SHALL check: 0x00000000 accepted -> TRAP from DECODE, instr_ready=0; rst -> IDLE, illegal=0, retired=0.
REQ-038 The bench SHALL check: 0x00208063 (beq) -> EXEC asserts Branch=1, PCWrite=1, ALUOp=0110, and the block is back in IDLE in 3 cycles.
REQ-039 The bench SHALL check: EN_ORI=0 with 0x0010E093 (ori) -> TRAP; and CNT_W=2 with 5 adds -> retired=1.

Source files
------------

// File: rtl/multicycle_control_if.sv
// Handshake and control bundle between fetch/memory side and the multicycle control FSM.
interface multicycle_control_if #(
    parameter int ALUOP_W = 4,
    parameter int CNT_W   = 16
);
    logic               instr_valid;
    logic [31:0]        instruction;
    logic               instr_ready;
    logic               mem_ready;
    logic [ALUOP_W-1:0] ALUOp;
    logic               ALUSrc;
    logic               MemtoReg;
    logic               MemRead;
    logic               MemWrite;
    logic               RegWrite;
    logic               Branch;
    logic               PCWrite;
    logic               IRWrite;
    logic               illegal;
    logic [2:0]         state;
    logic [CNT_W-1:0]   retired;

    modport master (
        output instr_valid, instruction, mem_ready,
        input  instr_ready, ALUOp, ALUSrc, MemtoReg, MemRead, MemWrite,
               RegWrite, Branch, PCWrite, IRWrite, illegal, state, retired
    );

    modport slave (
        input  instr_valid, instruction, mem_ready,
        output instr_ready, ALUOp, ALUSrc, MemtoReg, MemRead, MemWrite,
               RegWrite, Branch, PCWrite, IRWrite, illegal, state, retired
    );
endinterface

// File: rtl/multicycle_control.sv
// Multicycle RV32 subset control FSM: fetch handshake, decode, exec, memory wait with timeout, writeback.
// state  | meaning
// IDLE   | ready for a new instruction, latch IR on instr_valid
// DECODE | classify IR, illegal encodings go to TRAP
// EXEC   | ALU step; branches retire here
// MEM    | hold MemRead/MemWrite until mem_ready or timeout
// WB     | register writeback and PC update
// TRAP   | sticky illegal state, left only by rst
module multicycle_control #(
    parameter int ALUOP_W     = 4,
    parameter int MEM_TIMEOUT = 15,
    parameter int EN_ORI      = 1,
    parameter int CNT_W       = 16
) (
    input logic clk,
    input logic rst,
    multicycle_control_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        TRAP   = 3'd5
    } state_t;

    typedef enum logic [1:0] {K_ALU, K_BR, K_LW, K_SW} kind_t;

    localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

    state_t           st_q, st_d;
    logic [31:0]      ir;
    logic [7:0]       wait_cnt;
    logic [CNT_W-1:0] retired_q;
    kind_t            kind_q, dec_kind;
    logic [3:0]       op_q, dec_op;
    logic             src_q, dec_src, dec_legal;
    logic             retire, cnt_clr, cnt_inc, hold;
    logic             ready, irwrite, mrd, mwr, rw, m2r, br, pcw;
    logic [6:0]       opcode;
    logic [2:0]       funct3;
    logic [6:0]       funct7;
    logic             unused_ir;

    assign opcode    = ir[6:0];
    assign funct3    = ir[14:12];
    assign funct7    = ir[31:25];
    assign unused_ir = ^{ir[24:15], ir[11:7]};

    always_comb begin
        dec_kind  = K_ALU;
        dec_op    = 4'b0000;
        dec_src   = 1'b0;
        dec_legal = 1'b0;
        case (opcode)
            7'b0110011: begin
                if (funct7 == 7'b0000000) begin
                    case (funct3)
                        3'b000:  begin dec_legal = 1'b1; dec_op = 4'b0010; end
                        3'b111:  begin dec_legal = 1'b1; dec_op = 4'b0000; end
                        3'b110:  begin dec_legal = 1'b1; dec_op = 4'b0001; end
                        default: dec_legal = 1'b0;
                    endcase
                end else if (funct7 == 7'b0100000 && funct3 == 3'b000) begin
                    dec_legal = 1'b1;
                    dec_op    = 4'b0110;
                end
            end
            7'b1100011: begin
                if (funct3 == 3'b000 || funct3 == 3'b100) begin
                    dec_legal = 1'b1;
                    dec_kind  = K_BR;
                    dec_op    = 4'b0110;
                end
            end
            7'b0000011: begin
                if (funct3 == 3'b010) begin
                    dec_legal = 1'b1;
                    dec_kind  = K_LW;
                    dec_op    = 4'b0010;
                    dec_src   = 1'b1;
                end
            end
            7'b0100011: begin
                if (funct3 == 3'b010) begin
                    dec_legal = 1'b1;
                    dec_kind  = K_SW;
                    dec_op    = 4'b0010;
                    dec_src   = 1'b1;
                end
            end
            7'b0110111: begin
                dec_legal = 1'b1;
                dec_op    = 4'b0100;
                dec_src   = 1'b1;
            end
            7'b0010011: begin
                if (funct3 == 3'b000) begin
                    dec_legal = 1'b1;
                    dec_op    = 4'b0010;
                    dec_src   = 1'b1;
                end else if (funct3 == 3'b110 && EN_ORI != 0) begin
                    dec_legal = 1'b1;
                    dec_op    = 4'b0001;
                    dec_src   = 1'b1;
                end
            end
            default: dec_legal = 1'b0;
        endcase
    end

    always_comb begin
        st_d    = st_q;
        retire  = 1'b0;
        cnt_clr = 1'b0;
        cnt_inc = 1'b0;
        hold    = 1'b0;
        ready   = 1'b0;
        irwrite = 1'b0;
        mrd     = 1'b0;
        mwr     = 1'b0;
        rw      = 1'b0;
        m2r     = 1'b0;
        br      = 1'b0;
        pcw     = 1'b0;
        case (st_q)
            IDLE: begin
                ready = 1'b1;
                if (bus.instr_valid) begin
                    irwrite = 1'b1;
                    st_d    = DECODE;
                end
            end
            DECODE: st_d = dec_legal ? EXEC : TRAP;
            EXEC: begin
                hold = 1'b1;
                case (kind_q)
                    K_BR: begin
                        br     = 1'b1;
                        pcw    = 1'b1;
                        retire = 1'b1;
                        st_d   = IDLE;
                    end
                    K_LW, K_SW: begin
                        cnt_clr = 1'b1;
                        st_d    = MEM;
                    end
                    default: st_d = WB;
                endcase
            end
            MEM: begin
                hold = 1'b1;
                mrd  = (kind_q == K_LW);
                mwr  = (kind_q == K_SW);
                // completion wins over a timeout landing in the same cycle
                if (bus.mem_ready) begin
                    if (kind_q == K_LW) begin
                        st_d = WB;
                    end else begin
                        pcw    = 1'b1;
                        retire = 1'b1;
                        st_d   = IDLE;
                    end
                end else begin
                    cnt_inc = 1'b1;
                    if (wait_cnt == WAIT_LAST) st_d = TRAP;
                end
            end
            WB: begin
                hold   = 1'b1;
                rw     = 1'b1;
                pcw    = 1'b1;
                m2r    = (kind_q == K_LW);
                retire = 1'b1;
                st_d   = IDLE;
            end
            TRAP:    st_d = TRAP;
            default: st_d = TRAP;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st_q      <= IDLE;
            ir        <= '0;
            wait_cnt  <= '0;
            retired_q <= '0;
            kind_q    <= K_ALU;
            op_q      <= '0;
            src_q     <= 1'b0;
        end else begin
            st_q <= st_d;
            if (irwrite) ir <= bus.instruction;
            if (st_q == DECODE) begin
                kind_q <= dec_kind;
                op_q   <= dec_op;
                src_q  <= dec_src;
            end
            if (cnt_clr)      wait_cnt <= '0;
            else if (cnt_inc) wait_cnt <= wait_cnt + 8'd1;
            if (retire) retired_q <= retired_q + CNT_W'(1);
        end
    end

    assign bus.instr_ready = ready;
    assign bus.IRWrite     = irwrite;
    assign bus.ALUOp       = hold ? ALUOP_W'(op_q) : '0;
    assign bus.ALUSrc      = hold & src_q;
    assign bus.MemtoReg    = m2r;
    assign bus.MemRead     = mrd;
    assign bus.MemWrite    = mwr;
    assign bus.RegWrite    = rw;
    assign bus.Branch      = br;
    assign bus.PCWrite     = pcw;
    assign bus.illegal     = (st_q == TRAP);
    assign bus.state       = st_q;
    assign bus.retired     = retired_q;
endmodule
